riscv_aes_ctrl: RTL and testbench

RISCV_AES_CTRL -- requirements
Module: riscv_aes_ctrl

---
 rtl/riscv_aes_pkg.sv | 19 +
 rtl/riscv_aes_tmo_cnt.sv | 31 +++
 rtl/riscv_aes_ctrl.sv | 147 ++++++++++++++
 tb/tb_riscv_aes_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_aes_pkg.sv
// rtl/riscv_aes_pkg.sv - shared types and constants for the AES command controller
package riscv_aes_pkg;

    // Width of one AES block and of the result path to the writeback unit.
    localparam int AES_BLK_W = 128;

    // Default bound on cycles spent in RUN waiting for the core result.
    localparam int TIMEOUT_CYCLES_DEF = 64;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        WB_START = 3'd2,
        WB_WAIT  = 3'd3,
        DONE     = 3'd4
    } aes_state_e;

endpackage

// File: rtl/riscv_aes_tmo_cnt.sv
// rtl/riscv_aes_tmo_cnt.sv - RUN-state cycle counter flagging the terminal count
module riscv_aes_tmo_cnt
    import riscv_aes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] cnt_q;

    // Restart from zero when a command enters RUN, otherwise count RUN cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !tc) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Terminal count: this is the last RUN cycle the core is allowed.
    assign tc = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/riscv_aes_ctrl.sv
// rtl/riscv_aes_ctrl.sv - AES command sequencer (core -> AES -> writeback); RISCV_AES_TMO_EN adds RUN timeout
module riscv_aes_ctrl
    import riscv_aes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_decrypt,
    input  logic [31:0]          cmd_dst_addr,
    output logic                 aes_start,
    output logic                 aes_decrypt,
    input  logic                 aes_done,
    input  logic [AES_BLK_W-1:0] aes_result,
    output logic                 wb_start,
    output logic [31:0]          wb_addr,
    output logic [AES_BLK_W-1:0] wb_data,
    input  logic                 wb_halt,
    output logic                 halt_en_out,
    output logic                 done_o,
    output logic                 err_o
);

    aes_state_e           state_q;
    aes_state_e           state_d;
    logic                 accept;
    logic                 tmo_hit;
    logic                 mode_q;
    logic [31:0]          addr_q;
    logic [AES_BLK_W-1:0] res_q;
    logic                 start_q;
    logic                 seen_halt_q;

    assign accept = (state_q == IDLE) && cmd_valid;

`ifdef RISCV_AES_TMO_EN
    logic err_q;

    riscv_aes_tmo_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (state_q == RUN),
        .tc    (tmo_hit)
    );

    // Remember that this operation ended by timeout so DONE can flag it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state_q == RUN && !aes_done && tmo_hit) begin
            err_q <= 1'b1;
        end else if (state_q == DONE) begin
            err_q <= 1'b0;
        end
    end

    assign err_o = (state_q == DONE) && err_q;
`else
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a result arriving on the terminal-count cycle still wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (cmd_valid) state_d = RUN;
            RUN: begin
                if (aes_done) begin
                    state_d = WB_START;
                end else if (tmo_hit) begin
                    state_d = DONE;
                end
            end
            WB_START: state_d = WB_WAIT;
            WB_WAIT:  if (!wb_halt && seen_halt_q) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Command capture: mode is held for the whole operation, address until the next command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
            addr_q <= '0;
        end else if (accept) begin
            mode_q <= cmd_decrypt;
            addr_q <= cmd_dst_addr;
        end else if (state_q == DONE) begin
            mode_q <= 1'b0;
        end
    end

    // Result capture; only a result seen in RUN is taken, stray pulses elsewhere are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else if (state_q == RUN && aes_done) begin
            res_q <= aes_result;
        end
    end

    // AES start pulse lands in the first RUN cycle, one cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
        end else begin
            start_q <= accept;
        end
    end

    // Writeback handshake: wait for halt to be seen high, then low again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_halt_q <= 1'b0;
        end else if (state_q == WB_START) begin
            seen_halt_q <= 1'b0;
        end else if (state_q == WB_WAIT && wb_halt) begin
            seen_halt_q <= 1'b1;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign aes_start   = start_q;
    assign aes_decrypt = mode_q;
    assign wb_start    = (state_q == WB_START);
    assign wb_addr     = addr_q;
    assign wb_data     = res_q;
    assign halt_en_out = (state_q != IDLE);
    assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_riscv_aes_ctrl.sv
// tb/tb_riscv_aes_ctrl.sv - randomized self-checking bench for riscv_aes_ctrl
module tb_riscv_aes_ctrl;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_decrypt;
    logic [31:0]  cmd_dst_addr;
    logic         aes_start;
    logic         aes_decrypt;
    logic         aes_done;
    logic [127:0] aes_result;
    logic         wb_start;
    logic [31:0]  wb_addr;
    logic [127:0] wb_data;
    logic         wb_halt;
    logic         halt_en_out;
    logic         done_o;
    logic         err_o;

    int errors = 0;
    int checks = 0;
    int n_aes_start = 0;
    int n_wb_start = 0;
    int exp_aes_start = 0;
    int exp_wb_start = 0;

`ifdef RISCV_AES_TMO_EN
    localparam int DMAX = 7;
`else
    localparam int DMAX = 12;
`endif

    riscv_aes_ctrl #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_decrypt  (cmd_decrypt),
        .cmd_dst_addr (cmd_dst_addr),
        .aes_start    (aes_start),
        .aes_decrypt  (aes_decrypt),
        .aes_done     (aes_done),
        .aes_result   (aes_result),
        .wb_start     (wb_start),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_halt      (wb_halt),
        .halt_en_out  (halt_en_out),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (aes_start) n_aes_start++;
        if (wb_start)  n_wb_start++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string where);
        check({where, ".cmd_ready"},   cmd_ready,   1'b1);
        check({where, ".aes_start"},   aes_start,   1'b0);
        check({where, ".wb_start"},    wb_start,    1'b0);
        check({where, ".done_o"},      done_o,      1'b0);
        check({where, ".err_o"},       err_o,       1'b0);
        check({where, ".halt_en_out"}, halt_en_out, 1'b0);
        check({where, ".aes_decrypt"}, aes_decrypt, 1'b0);
        check({where, ".wb_addr"},     wb_addr,     32'h0);
        check({where, ".wb_data"},     wb_data,     128'h0);
    endtask

    // One full operation: result arrives d cycles after the start pulse,
    // the writeback unit holds halt for h cycles.
    task automatic run_txn(input logic mode, input logic [31:0] addr, input logic [127:0] res,
                           input int d, input int h, input bit poke);
        cmd_valid    = 1'b1;
        cmd_decrypt  = mode;
        cmd_dst_addr = addr;
        check("idle_ready", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
        exp_aes_start++;
        check("start_pulse", aes_start, 1'b1);
        check("busy_not_ready", cmd_ready, 1'b0);
        check("run_halt_en", halt_en_out, 1'b1);
        check("run_mode", aes_decrypt, mode);
        for (int c = 1; c <= d; c++) begin
            step();
            check("start_once", aes_start, 1'b0);
            check("no_early_wb", wb_start, 1'b0);
            check("run_no_err", err_o, 1'b0);
            if (poke) begin
                cmd_valid    = 1'b1;
                cmd_decrypt  = ~mode;
                cmd_dst_addr = ~addr;
                check("poke_not_ready", cmd_ready, 1'b0);
            end
        end
        aes_done   = 1'b1;
        aes_result = res;
        step();
        aes_done   = 1'b0;
        aes_result = {$urandom, $urandom, $urandom, $urandom};
        cmd_valid  = 1'b0;
        exp_wb_start++;
        check("wb_start", wb_start, 1'b1);
        check("wb_addr", wb_addr, addr);
        check("wb_data", wb_data, res);
        check("wb_mode_held", aes_decrypt, mode);
        step();
        check("wb_start_once", wb_start, 1'b0);
        wb_halt = 1'b1;
        for (int i = 0; i < h; i++) begin
            aes_done   = 1'($urandom_range(0, 1));
            aes_result = {$urandom, $urandom, $urandom, $urandom};
            step();
            check("halt_no_done", done_o, 1'b0);
            check("halt_data_stable", wb_data, res);
        end
        aes_done = 1'b0;
        wb_halt  = 1'b0;
        step();
        check("done_pulse", done_o, 1'b1);
        check("done_no_err", err_o, 1'b0);
        check("done_halt_en", halt_en_out, 1'b1);
        check("done_addr", wb_addr, addr);
        check("done_data", wb_data, res);
        step();
        check("back_ready", cmd_ready, 1'b1);
        check("done_once", done_o, 1'b0);
        check("idle_halt_en", halt_en_out, 1'b0);
        check("idle_mode", aes_decrypt, 1'b0);
    endtask

`ifdef RISCV_AES_TMO_EN
    task automatic run_timeout(input logic mode, input logic [31:0] addr);
        cmd_valid    = 1'b1;
        cmd_decrypt  = mode;
        cmd_dst_addr = addr;
        step();
        cmd_valid = 1'b0;
        exp_aes_start++;
        check("tmo_start", aes_start, 1'b1);
        for (int c = 1; c < 8; c++) begin
            step();
            check("tmo_early_done", done_o, 1'b0);
            check("tmo_no_wb", wb_start, 1'b0);
        end
        step();
        check("tmo_done", done_o, 1'b1);
        check("tmo_err", err_o, 1'b1);
        check("tmo_halt_en", halt_en_out, 1'b1);
        step();
        check("tmo_back_ready", cmd_ready, 1'b1);
        check("tmo_err_once", err_o, 1'b0);
    endtask
`endif

    initial begin
        rst_n        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_decrypt  = 1'b0;
        cmd_dst_addr = 32'h0;
        aes_done     = 1'b0;
        aes_result   = 128'h0;
        wb_halt      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Encrypt path with fixed timing and data.
        run_txn(1'b0, 32'h0000_1000, 128'h00112233_44556677_8899AABB_CCDDEEFF,
                (DMAX < 10) ? DMAX : 10, 6, 1'b0);

        // Busy rejection.
        run_txn(1'b1, 32'h0000_2000, 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678, 4, 2, 1'b1);

        // Stray result pulse while idle.
        aes_done   = 1'b1;
        aes_result = 128'hFFFF;
        step();
        aes_done = 1'b0;
        step();
        check("stray_ready", cmd_ready, 1'b1);
        check("stray_halt_en", halt_en_out, 1'b0);
        check("stray_wb_data", wb_data, 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678);

        // Randomized operations.
        for (int t = 0; t < 10; t++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom,
                    {$urandom, $urandom, $urandom, $urandom},
                    $urandom_range(1, DMAX), $urandom_range(1, 6),
                    1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) step();
        end

`ifdef RISCV_AES_TMO_EN
        run_timeout(1'b1, 32'h0000_3000);
        // Result on the terminal-count cycle is taken as a normal completion.
        run_txn(1'b0, 32'h0000_4000, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 7, 3, 1'b0);
`endif

        // Reset during the writeback wait.
        cmd_valid    = 1'b1;
        cmd_decrypt  = 1'b1;
        cmd_dst_addr = 32'h0000_5000;
        step();
        cmd_valid = 1'b0;
        exp_aes_start++;
        step();
        aes_done   = 1'b1;
        aes_result = 128'h5555_AAAA;
        step();
        aes_done = 1'b0;
        exp_wb_start++;
        step();
        wb_halt = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        wb_halt = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        run_txn(1'b0, 32'h0000_6000, 128'h6666_7777_8888_9999, 3, 2, 1'b0);

        check("aes_start_count", 128'(n_aes_start), 128'(exp_aes_start));
        check("wb_start_count", 128'(n_wb_start), 128'(exp_wb_start));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
